// File: rtl/k12a_spi_master_pkg.sv
// k12a_spi_master_pkg: shared mode/state types for the k12a SPI master engine.
package k12a_spi_master_pkg;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  typedef logic [1:0] spi_master_state_t;
  localparam spi_master_state_t ST_IDLE   = 2'd0;
  localparam spi_master_state_t ST_SETUP  = 2'd1;
  localparam spi_master_state_t ST_XFER   = 2'd2;
  localparam spi_master_state_t ST_FINISH = 2'd3;
endpackage

// File: rtl/k12a_spi_master_if.sv
// k12a_spi_master_if: control strobes, data and serial pins of the SPI master.
interface k12a_spi_master_if
  import k12a_spi_master_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DIV_WIDTH    = 8,
  parameter int NUM_CS       = 1,
  parameter int CS_SEL_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) ();
  logic                    spi_begin;
  logic                    spi_data_io_store;
  logic [DATA_WIDTH-1:0]   spi_data_in;
  spi_mode_t               spi_mode;
  logic [DIV_WIDTH-1:0]    spi_divider;
  logic [CS_SEL_WIDTH-1:0] spi_cs_index;
  logic [DATA_WIDTH-1:0]   spi_data_out;
  logic                    spi_busy;
  logic                    spi_done;
  logic                    spi_sck;
  logic                    spi_mosi;
  logic                    spi_miso;
  logic [NUM_CS-1:0]       spi_cs_n;
  modport master (
    input  spi_begin, spi_data_io_store, spi_data_in, spi_mode, spi_divider, spi_cs_index, spi_miso,
    output spi_data_out, spi_busy, spi_done, spi_sck, spi_mosi, spi_cs_n
  );
  modport slave (
    output spi_begin, spi_data_io_store, spi_data_in, spi_mode, spi_divider, spi_cs_index, spi_miso,
    input  spi_data_out, spi_busy, spi_done, spi_sck, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/k12a_spi_master_clkdiv.sv
// k12a_spi_master_clkdiv: SCK half-period counter, 0..div, tick at terminal count.
module k12a_spi_master_clkdiv #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == div;
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/k12a_spi_master.sv
// k12a_spi_master: SPI master with configurable frame width, CPOL/CPHA,
// SCK divider and chip-select fan-out.
module k12a_spi_master
  import k12a_spi_master_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DIV_WIDTH    = 8,
  parameter int NUM_CS       = 1,
  parameter int CS_SEL_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input logic               clock,
  input logic               reset_n,
  k12a_spi_master_if.master bus
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  spi_master_state_t     state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d, cs_sel_n;
  logic sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic tick, idle, leading, last, sample, drive;
  k12a_spi_master_clkdiv #(.DIV_WIDTH(DIV_WIDTH)) u_clkdiv (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (idle),
    .div     (div_q),
    .tick    (tick)
  );
  always_comb begin
    idle    = state_q == ST_IDLE;
    leading = sck_q == mode_q.cpol;
    last    = edge_q == '0;
    sample  = leading ^ mode_q.cpha;
    drive   = mode_q.cpha ? leading : !leading && !last;
    for (int i = 0; i < NUM_CS; i++) cs_sel_n[i] = bus.spi_cs_index != CS_SEL_WIDTH'(i);
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (idle) begin
      sck_d = bus.spi_mode.cpol;
      if (bus.spi_data_io_store) shift_d = bus.spi_data_in;
      if (bus.spi_begin) begin
        state_d = ST_SETUP;
        mode_d  = bus.spi_mode;
        div_d   = bus.spi_divider;
        cs_n_d  = cs_sel_n;
        busy_d  = 1'b1;
        edge_d  = EW'(2 * DATA_WIDTH - 1);
        if (!bus.spi_mode.cpha) mosi_d = shift_d[DATA_WIDTH-1];
      end
    end else if (tick) begin
      if (state_q == ST_FINISH) begin
        state_d = ST_IDLE;
        cs_n_d  = '1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else if (state_q == ST_XFER && last && leading) begin
        // all edges issued and SCK is back at CPOL: one more half-period before FINISH
        state_d = ST_FINISH;
      end else begin
        state_d = ST_XFER;
        sck_d   = !sck_q;
        edge_d  = last ? edge_q : edge_q - 1'b1;
        if (sample) shift_d = {shift_q[DATA_WIDTH-2:0], bus.spi_miso};
        if (drive) mosi_d = shift_q[DATA_WIDTH-1];
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.spi_data_out = shift_q;
  assign bus.spi_busy     = busy_q;
  assign bus.spi_done     = done_q;
  assign bus.spi_sck      = sck_q;
  assign bus.spi_mosi     = mosi_q;
  assign bus.spi_cs_n     = cs_n_q;
endmodule

// File: tb/tb_k12a_spi_master.sv
// tb_k12a_spi_master: directed and random frames against a behavioural SPI slave
// model; covers 8-bit/4-CS and 16-bit/divider-3 instances.
module tb_k12a_spi_master;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;

  k12a_spi_master_if #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(4), .CS_SEL_WIDTH(3)) b8 ();
  k12a_spi_master_if #(.DATA_WIDTH(16), .DIV_WIDTH(8), .NUM_CS(1)) b16 ();
  k12a_spi_master #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(4), .CS_SEL_WIDTH(3)) u8 (
    .clock(clock), .reset_n(reset_n), .bus(b8));
  k12a_spi_master #(.DATA_WIDTH(16), .DIV_WIDTH(8), .NUM_CS(1)) u16 (
    .clock(clock), .reset_n(reset_n), .bus(b16));

  logic lb8 = 1'b0;
  logic s_miso = 1'b0;
  assign b8.spi_miso  = lb8 ? b8.spi_mosi : s_miso;
  assign b16.spi_miso = b16.spi_mosi;

  // slave model for the 8-bit instance: captures MOSI on sampling edges,
  // presents the next pattern bit on the opposite edges
  logic [1:0] cfg_mode = 2'b00;
  logic [7:0] cfg_pat = 8'h00;
  logic pbusy = 1'b0, psck = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
  logic [7:0] s_pat = 8'h00, rx8 = 8'h00;
  logic [3:0] cs_and = 4'hF, cs_or = 4'h0;
  int edges8 = 0, nsh = 0;
  always @(negedge clock) begin
    if (b8.spi_busy && !pbusy) begin
      s_cpol = cfg_mode[1];
      s_cpha = cfg_mode[0];
      s_pat  = cfg_pat;
      edges8 = 0;
      nsh    = 0;
      rx8    = 8'h00;
      s_miso = cfg_pat[7];
      cs_and = 4'hF;
      cs_or  = 4'h0;
    end else if (b8.spi_busy && b8.spi_sck !== psck) begin
      edges8++;
      if ((b8.spi_sck != s_cpol) ^ s_cpha) rx8 = {rx8[6:0], b8.spi_mosi};
      else begin
        if (!s_cpha) nsh++;
        s_miso = (nsh < 8) ? s_pat[7-nsh] : 1'b0;
        if (s_cpha) nsh++;
      end
    end
    if (b8.spi_busy) begin
      cs_and = cs_and & b8.spi_cs_n;
      cs_or  = cs_or | b8.spi_cs_n;
    end
    pbusy = b8.spi_busy;
    psck  = b8.spi_sck;
  end

  logic pbusy16 = 1'b0, psck16 = 1'b0;
  int cyc16 = 0, lastc16 = 0, edges16 = 0, gmin16 = 0, gmax16 = 0;
  always @(negedge clock) begin
    cyc16++;
    if (b16.spi_busy && !pbusy16) begin
      edges16 = 0;
      gmin16  = 1000;
      gmax16  = 0;
    end else if (b16.spi_busy && b16.spi_sck !== psck16) begin
      edges16++;
      if (edges16 > 1) begin
        gmin16 = (cyc16 - lastc16 < gmin16) ? cyc16 - lastc16 : gmin16;
        gmax16 = (cyc16 - lastc16 > gmax16) ? cyc16 - lastc16 : gmax16;
      end
      lastc16 = cyc16;
    end
    pbusy16 = b16.spi_busy;
    psck16  = b16.spi_sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run8(input logic [7:0] data, input logic [1:0] mode, input logic [7:0] div,
                      input logic [2:0] cs, input logic [7:0] pat, input logic loop,
                      input logic same, input logic disturb);
    int n;
    int exp_lat;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
    exp_lat  = 2 * (int'(div) + 1) + 16 * (int'(div) + 1) + 1;
    exp_rx   = loop ? data : pat;
    exp_cs   = (cs < 3'd4) ? ~(4'b0001 << cs) : 4'hF;
    cfg_mode = mode;
    cfg_pat  = pat;
    lb8      = loop;
    b8.spi_mode     = mode;
    b8.spi_divider  = div;
    b8.spi_cs_index = cs;
    b8.spi_data_in  = data;
    b8.spi_data_io_store = 1'b1;
    if (!same) begin
      step();
      b8.spi_data_io_store = 1'b0;
      b8.spi_data_in = ~data;
      step();
      chk("idle_sck_pre", b8.spi_sck, mode[1]);
    end
    b8.spi_begin = 1'b1;
    step();
    b8.spi_begin = 1'b0;
    b8.spi_data_io_store = 1'b0;
    b8.spi_data_in = ~data;
    chk("busy_set", b8.spi_busy, 1'b1);
    n = 1;
    while (!b8.spi_done && n < 4000) begin
      if (disturb && n == 4) begin
        b8.spi_begin = 1'b1;
        b8.spi_data_io_store = 1'b1;
        b8.spi_data_in = 8'hFF;
        b8.spi_mode = ~mode;
        b8.spi_divider = div + 8'd1;
        b8.spi_cs_index = 3'd0;
      end
      if (disturb && n == 5) begin
        b8.spi_begin = 1'b0;
        b8.spi_data_io_store = 1'b0;
        b8.spi_mode = mode;
        b8.spi_divider = div;
        b8.spi_cs_index = cs;
      end
      step();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("rx_data", b8.spi_data_out, exp_rx);
    chk("mosi_bits", rx8, data);
    chk("sck_edges", edges8, 16);
    chk("cs_and", cs_and, exp_cs);
    chk("cs_or", cs_or, exp_cs);
    chk("busy_clr", b8.spi_busy, 1'b0);
    step();
    chk("done_pulse", b8.spi_done, 1'b0);
    chk("idle_sck_post", b8.spi_sck, mode[1]);
    if (disturb) begin
      repeat (20) step();
      chk("no_restart", b8.spi_busy, 1'b0);
      chk("rx_kept", b8.spi_data_out, exp_rx);
    end
  endtask

  initial begin
    int n;
    b8.spi_begin = 1'b0;
    b8.spi_data_io_store = 1'b0;
    b8.spi_data_in = 8'h00;
    b8.spi_mode = 2'b00;
    b8.spi_divider = 8'd0;
    b8.spi_cs_index = 3'd0;
    b16.spi_begin = 1'b0;
    b16.spi_data_io_store = 1'b0;
    b16.spi_data_in = 16'h0000;
    b16.spi_mode = 2'b00;
    b16.spi_divider = 8'd0;
    b16.spi_cs_index = 1'b0;
    repeat (3) step();
    chk("rst_busy", b8.spi_busy, 1'b0);
    chk("rst_done", b8.spi_done, 1'b0);
    chk("rst_sck", b8.spi_sck, 1'b0);
    chk("rst_mosi", b8.spi_mosi, 1'b0);
    chk("rst_cs", b8.spi_cs_n, 4'hF);
    chk("rst_data", b8.spi_data_out, 8'h00);
    chk("rst_cs16", b16.spi_cs_n, 1'b1);
    chk("rst_data16", b16.spi_data_out, 16'h0000);
    reset_n = 1'b1;
    step();

    run8(8'hA5, 2'b00, 8'd0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    run8(8'h3C, 2'b01, 8'd0, 3'd1, 8'hC3, 1'b0, 1'b0, 1'b0);
    run8(8'h3C, 2'b10, 8'd1, 3'd2, 8'hC3, 1'b0, 1'b0, 1'b0);
    run8(8'h3C, 2'b11, 8'd2, 3'd3, 8'hC3, 1'b0, 1'b0, 1'b0);
    run8(8'h5E, 2'b00, 8'd0, 3'd2, 8'h96, 1'b0, 1'b0, 1'b0);
    run8(8'h5E, 2'b01, 8'd0, 3'd5, 8'h96, 1'b0, 1'b0, 1'b0);
    run8(8'h81, 2'b00, 8'd0, 3'd0, 8'h42, 1'b0, 1'b1, 1'b1);

    b16.spi_divider = 8'd3;
    b16.spi_data_in = 16'h8001;
    b16.spi_data_io_store = 1'b1;
    step();
    b16.spi_data_io_store = 1'b0;
    b16.spi_begin = 1'b1;
    step();
    b16.spi_begin = 1'b0;
    n = 1;
    while (!b16.spi_done && n < 4000) begin
      step();
      n++;
    end
    chk("lat16", n, 137);
    chk("data16", b16.spi_data_out, 16'h8001);
    chk("edges16", edges16, 32);
    chk("gap16_min", gmin16, 4);
    chk("gap16_max", gmax16, 4);
    chk("cs16_idle", b16.spi_cs_n, 1'b1);

    cfg_mode = 2'b11;
    cfg_pat = 8'h5A;
    lb8 = 1'b0;
    b8.spi_mode = 2'b11;
    b8.spi_divider = 8'd1;
    b8.spi_cs_index = 3'd0;
    b8.spi_data_in = 8'h77;
    b8.spi_data_io_store = 1'b1;
    step();
    b8.spi_data_io_store = 1'b0;
    b8.spi_begin = 1'b1;
    step();
    b8.spi_begin = 1'b0;
    repeat (6) step();
    chk("pre_rst_cs", b8.spi_cs_n, 4'b1110);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sck", b8.spi_sck, 1'b0);
    chk("mid_rst_cs", b8.spi_cs_n, 4'hF);
    chk("mid_rst_busy", b8.spi_busy, 1'b0);
    chk("mid_rst_data", b8.spi_data_out, 8'h00);
    step();
    reset_n = 1'b1;
    step();
    run8(8'h6B, 2'b11, 8'd1, 3'd1, 8'hD4, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++)
      run8(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
           3'($urandom_range(0, 4)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
